// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - RISC-V writeback stage: load extract, result mux, 32x32 register file, retire counter
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        validw,
    input  logic        regwritew,
    input  logic [1:0]  resultsrcw,
    input  logic [2:0]  funct3w,
    input  logic [4:0]  rdw,
    input  logic [31:0] aluresultw,
    input  logic [31:0] readdataw,
    input  logic [31:0] pcplus4w,
    input  logic [4:0]  a1d,
    input  logic [4:0]  a2d,
    output logic [31:0] rd1d,
    output logic [31:0] rd2d,
    output logic [31:0] resultw,
    output logic [63:0] instret
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        write_en;

    always_comb begin
        load_byte = readdataw[7:0];
        case (aluresultw[1:0])
            2'd0:    load_byte = readdataw[7:0];
            2'd1:    load_byte = readdataw[15:8];
            2'd2:    load_byte = readdataw[23:16];
            default: load_byte = readdataw[31:24];
        endcase
        load_half = aluresultw[1] ? readdataw[31:16] : readdataw[15:0];
        case (funct3w)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_data = {24'h0, load_byte};
            F3_LHU:  load_data = {16'h0, load_half};
            default: load_data = readdataw;
        endcase
    end

    always_comb begin
        case (resultsrcw)
            2'b00:   resultw = aluresultw;
            2'b01:   resultw = load_data;
            2'b10:   resultw = pcplus4w;
            default: resultw = 32'h0;
        endcase
    end

    // x0 writes are dropped here, so the bypass below never forwards onto x0
    assign write_en = regwritew && validw && (rdw != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[rdw] = resultw;
        end
        instret_d = validw ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
            instret_q <= 64'h0;
        end else begin
            regs_q    <= regs_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        if (write_en && (a1d == rdw)) begin
            rd1d = resultw;
        end else if (a1d == 5'd0) begin
            rd1d = 32'h0;
        end else begin
            rd1d = regs_q[a1d];
        end
        if (write_en && (a2d == rdw)) begin
            rd2d = resultw;
        end else if (a2d == 5'd0) begin
            rd2d = 32'h0;
        end else begin
            rd2d = regs_q[a2d];
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        validw;
    logic        regwritew;
    logic [1:0]  resultsrcw;
    logic [2:0]  funct3w;
    logic [4:0]  rdw;
    logic [31:0] aluresultw;
    logic [31:0] readdataw;
    logic [31:0] pcplus4w;
    logic [4:0]  a1d;
    logic [4:0]  a2d;
    logic [31:0] rd1d;
    logic [31:0] rd2d;
    logic [31:0] resultw;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .validw     (validw),
        .regwritew  (regwritew),
        .resultsrcw (resultsrcw),
        .funct3w    (funct3w),
        .rdw        (rdw),
        .aluresultw (aluresultw),
        .readdataw  (readdataw),
        .pcplus4w   (pcplus4w),
        .a1d        (a1d),
        .a2d        (a2d),
        .rd1d       (rd1d),
        .rd2d       (rd2d),
        .resultw    (resultw),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        validw     = 1'b0;
        regwritew  = 1'b0;
        resultsrcw = 2'b00;
        funct3w    = 3'b010;
        rdw        = 5'd0;
        aluresultw = 32'h0;
        readdataw  = 32'h0;
        pcplus4w   = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        a1d = 5'd5;
        a2d = 5'd31;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        #12;
        exp = exp_q.pop_front(); checks++;
        if (instret !== exp) begin errors++; $display("FAIL reset_instret actual=%h expected=%h", instret, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL reset_rd1d actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL reset_rd2d actual=%h expected=%h", rd2d, exp[31:0]); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        validw = 1'b1; regwritew = 1'b1; resultsrcw = 2'b00;
        rdw = 5'd5; aluresultw = 32'hDEADBEEF;
        a1d = 5'd0; a2d = 5'd0;
        @(negedge clk);
        idle();
        a1d = 5'd5; a2d = 5'd0;
        exp_q.push_back(64'hDEADBEEF);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'd1);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL wr_x5_rd1d actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL wr_x0_rd2d actual=%h expected=%h", rd2d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (instret !== exp) begin errors++; $display("FAIL wr_instret actual=%0d expected=%0d", instret, exp); end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adr [5] = '{32'h1000, 32'h1002, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] res [5] = '{32'hFFFF_FF81, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_7F81, 32'h80F0_7F81};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            resultsrcw = 2'b01;
            readdataw  = 32'h80F0_7F81;
            funct3w    = f3[i];
            aluresultw = adr[i];
            exp_q.push_back({32'h0, res[i]});
            #1;
            exp = exp_q.pop_front(); checks++;
            if (resultw !== exp[31:0]) begin errors++; $display("FAIL load_f3_%b actual=%h expected=%h", f3[i], resultw, exp[31:0]); end
        end
    endtask

    task automatic test_write_x0();
        @(negedge clk);
        idle();
        validw = 1'b1; regwritew = 1'b1; resultsrcw = 2'b10;
        pcplus4w = 32'h100; rdw = 5'd0;
        a1d = 5'd0; a2d = 5'd5;
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (resultw !== exp[31:0]) begin errors++; $display("FAIL x0_resultw actual=%h expected=%h", resultw, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL x0_bypass_rd1d actual=%h expected=%h", rd1d, exp[31:0]); end
        @(negedge clk);
        idle();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'hDEADBEEF);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL x0_after_rd1d actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL x0_x5_kept actual=%h expected=%h", rd2d, exp[31:0]); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        validw = 1'b1; regwritew = 1'b1; resultsrcw = 2'b00;
        rdw = 5'd7; aluresultw = 32'h1234;
        a1d = 5'd7; a2d = 5'd7;
        exp_q.push_back(64'h1234);
        exp_q.push_back(64'h1234);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL bypass_rd1d actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL bypass_rd2d actual=%h expected=%h", rd2d, exp[31:0]); end
        @(negedge clk);
        idle();
        exp_q.push_back(64'h1234);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL bypass_stored actual=%h expected=%h", rd2d, exp[31:0]); end
    endtask

    task automatic test_write_blocking();
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        validw = 1'b0; regwritew = 1'b1; rdw = 5'd9; aluresultw = 32'h55;
        @(negedge clk);
        idle();
        a1d = 5'd9;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL block_x9 actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (instret !== exp) begin errors++; $display("FAIL block_instret actual=%0d expected=%0d", instret, exp); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            validw = 1'b1; regwritew = (i != 1); rdw = 5'd10 + 5'(i);
            aluresultw = 32'h100 + 32'(i);
        end
        @(negedge clk);
        idle();
        a1d = 5'd11; a2d = 5'd12;
        exp_q.push_back(64'd3);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h102);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (instret !== exp) begin errors++; $display("FAIL three_instret actual=%0d expected=%0d", instret, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL nowrite_x11 actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL write_x12 actual=%h expected=%h", rd2d, exp[31:0]); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        idle();
        validw = 1'b1; regwritew = 1'b1; rdw = 5'd3; aluresultw = 32'hA5;
        @(negedge clk);
        aluresultw = 32'h77; rdw = 5'd4;
        a1d = 5'd3; a2d = 5'd4;
        #1;
        exp_q.push_back(64'hA5);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL mid_x3_before actual=%h expected=%h", rd1d, exp[31:0]); end
        reset = 1'b1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h77);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd1d !== exp[31:0]) begin errors++; $display("FAIL mid_x3_cleared actual=%h expected=%h", rd1d, exp[31:0]); end
        exp = exp_q.pop_front(); checks++;
        if (instret !== exp) begin errors++; $display("FAIL mid_instret_cleared actual=%0d expected=%0d", instret, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL mid_bypass_in_reset actual=%h expected=%h", rd2d, exp[31:0]); end
        @(negedge clk);
        idle();
        reset = 1'b0;
        exp_q.push_back(64'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rd2d !== exp[31:0]) begin errors++; $display("FAIL mid_write_lost actual=%h expected=%h", rd2d, exp[31:0]); end
    endtask

    task automatic test_instret_wrap();
        @(negedge clk);
        idle();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        validw = 1'b1;
        @(negedge clk);
        idle();
        exp_q.push_back(64'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (instret !== exp) begin errors++; $display("FAIL instret_wrap actual=%h expected=%h", instret, exp); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_extract();
        test_write_x0();
        test_bypass();
        test_write_blocking();
        test_reset_midstream();
        test_instret_wrap();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
